// File: rtl/flash_dma_pkg.sv
// flash_dma_pkg: shared register map, flash device status bits and FSM encoding for flash_dma.
package flash_dma_pkg;
  localparam logic [1:0] REG_CTRL = 2'd0, REG_BLOCK = 2'd1, REG_MEMADDR = 2'd2, REG_COUNT = 2'd3;
  localparam int CTRL_START = 0, CTRL_DIR = 1, CTRL_DONE = 31;
  localparam int FS_DONE = 31, FS_READ = 30, FS_WRITE = 29;
  localparam int BLK_LEN = 128;
  localparam logic [6:0] LAST_IDX = 7'(BLK_LEN - 1);
  localparam logic [2:0] S_IDLE = 3'd0, S_FILL = 3'd1, S_KICK = 3'd2, S_POLL = 3'd3,
                         S_CLEAR = 3'd4, S_DRAIN = 3'd5, S_NEXT = 3'd6, S_FINISH = 3'd7;
  function automatic logic [31:0] kick_word(input logic dir, input logic [25:0] blk);
    kick_word = {6'd0, blk};
    kick_word[FS_READ] = ~dir;
    kick_word[FS_WRITE] = dir;
  endfunction
endpackage

// File: rtl/flash_dma_xfer.sv
// flash_dma_xfer: single-transfer bus engine; registers one request and holds it until acked.
module flash_dma_xfer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic [31:0] m_addr_o,
  output logic [31:0] m_data_o,
  input  logic [31:0] m_data_i,
  output logic        m_rd_o,
  output logic        m_we_o,
  input  logic        m_ack_i
);
  logic rd_q, we_q;
  logic [31:0] addr_q, data_q;
  // A new request is only accepted with the strobe low, which guarantees the idle gap.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_q <= 1'b0;
      we_q <= 1'b0;
      addr_q <= 32'd0;
      data_q <= 32'd0;
    end else if (rd_q || we_q) begin
      if (m_ack_i) begin
        rd_q <= 1'b0;
        we_q <= 1'b0;
      end
    end else if (req_i) begin
      rd_q <= ~we_i;
      we_q <= we_i;
      addr_q <= addr_i;
      data_q <= wdata_i;
    end
  assign done_o = (rd_q || we_q) && m_ack_i;
  assign rdata_o = m_data_i;
  assign m_addr_o = addr_q;
  assign m_data_o = data_q;
  assign m_rd_o = rd_q;
  assign m_we_o = we_q;
endmodule

// File: rtl/flash_dma.sv
// flash_dma: bus-master DMA that drives the flash block device and moves 128-word blocks to/from memory.
module flash_dma
  import flash_dma_pkg::*;
#(
  parameter logic [31:0] FLASH_CTRL_ADDR = 32'hFFFF_FE00,
  parameter logic [31:0] FLASH_BUF_BASE  = 32'hFFFF_F000,
  parameter logic [23:0] POLL_LIMIT      = 24'hFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  s_addr_i,
  input  logic [31:0] s_data_i,
  output logic [31:0] s_data_o,
  input  logic        s_we_i,
  output logic        s_ack_o,
  output logic [31:0] m_addr_o,
  output logic [31:0] m_data_o,
  input  logic [31:0] m_data_i,
  output logic [1:0]  m_sel_o,
  output logic        m_rd_o,
  output logic        m_we_o,
  input  logic        m_ack_i,
  output logic        interrupt
);
  logic dir_q, dir_d, err_q, err_d, done_q, done_d, ph_q, ph_d;
  logic [2:0] st_q, st_d;
  logic [25:0] block_q, wblock_q, wblock_d;
  logic [31:0] memaddr_q, wa_q, wa_d, buf_q, buf_d;
  logic [15:0] count_q, wcount_q, wcount_d;
  logic [6:0] idx_q, idx_d;
  logic [23:0] poll_q, poll_d;
  logic [1:0] sel;
  logic busy, cfg_wr, start, go, req, xwe, xdone, unused_ok;
  logic [31:0] xaddr, xwdata, rdata, offs;
  assign sel = s_addr_i[3:2];
  assign unused_ok = &{1'b0, s_addr_i[1:0]};
  assign busy = st_q != S_IDLE;
  assign cfg_wr = s_we_i && !busy;
  assign start = cfg_wr && sel == REG_CTRL && s_data_i[CTRL_START];
  assign go = start && count_q != 16'd0;
  assign offs = {23'd0, idx_q, 2'b00};
  assign req = st_q inside {S_FILL, S_KICK, S_POLL, S_CLEAR, S_DRAIN};
  assign s_ack_o = 1'b1;
  assign m_sel_o = 2'd2;
  assign interrupt = done_q;
  assign s_data_o = sel == REG_CTRL  ? {done_q, busy, err_q, 27'd0, dir_q, 1'b0} :
                    sel == REG_BLOCK ? {6'd0, block_q} :
                    sel == REG_MEMADDR ? memaddr_q : {16'd0, count_q};
  // Block phases alternate a read (ph 0) and a write (ph 1) per word index.
  always_comb begin
    xwe = 1'b1;
    xaddr = FLASH_CTRL_ADDR;
    xwdata = 32'd0;
    case (st_q)
      S_FILL: begin
        xwe = ph_q;
        xaddr = ph_q ? FLASH_BUF_BASE + offs : wa_q + offs;
        xwdata = buf_q;
      end
      S_KICK: xwdata = kick_word(dir_q, wblock_q);
      S_POLL: xwe = 1'b0;
      S_DRAIN: begin
        xwe = ph_q;
        xaddr = ph_q ? wa_q + offs : FLASH_BUF_BASE + offs;
        xwdata = buf_q;
      end
      default: ;
    endcase
  end
  always_comb begin
    st_d = st_q;
    wblock_d = wblock_q;
    wa_d = wa_q;
    wcount_d = wcount_q;
    idx_d = idx_q;
    ph_d = ph_q;
    buf_d = buf_q;
    poll_d = poll_q;
    err_d = err_q;
    done_d = done_q && !(s_we_i && sel == REG_CTRL && s_data_i[CTRL_DONE]);
    dir_d = (cfg_wr && sel == REG_CTRL) ? s_data_i[CTRL_DIR] : dir_q;
    case (st_q)
      S_IDLE:
        if (go) begin
          st_d = s_data_i[CTRL_DIR] ? S_FILL : S_KICK;
          err_d = 1'b0;
          done_d = 1'b0;
          wblock_d = block_q;
          wa_d = memaddr_q;
          wcount_d = count_q;
          idx_d = 7'd0;
          ph_d = 1'b0;
        end else if (start) done_d = 1'b1;
      S_FILL, S_DRAIN:
        if (xdone) begin
          ph_d = ~ph_q;
          buf_d = ph_q ? buf_q : rdata;
          if (ph_q) begin
            idx_d = idx_q + 7'd1;
            if (idx_q == LAST_IDX) st_d = st_q == S_FILL ? S_KICK : S_NEXT;
          end
        end
      S_KICK:
        if (xdone) begin
          st_d = S_POLL;
          poll_d = 24'd0;
        end
      S_POLL:
        if (xdone) begin
          poll_d = poll_q + 24'd1;
          st_d = (rdata[FS_DONE] || poll_d == POLL_LIMIT) ? S_CLEAR : S_POLL;
          err_d = !rdata[FS_DONE] && poll_d == POLL_LIMIT;
        end
      S_CLEAR: if (xdone) st_d = err_q ? S_FINISH : dir_q ? S_NEXT : S_DRAIN;
      S_NEXT: begin
        wblock_d = wblock_q + 26'd1;
        wa_d = wa_q + 32'd512;
        wcount_d = wcount_q - 16'd1;
        st_d = wcount_q == 16'd1 ? S_FINISH : dir_q ? S_FILL : S_KICK;
      end
      S_FINISH: begin
        done_d = 1'b1;
        st_d = S_IDLE;
      end
      default: st_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st_q <= S_IDLE;
      dir_q <= 1'b0;
      err_q <= 1'b0;
      done_q <= 1'b0;
      block_q <= 26'd0;
      memaddr_q <= 32'd0;
      count_q <= 16'd0;
      wblock_q <= 26'd0;
      wa_q <= 32'd0;
      wcount_q <= 16'd0;
      idx_q <= 7'd0;
      ph_q <= 1'b0;
      buf_q <= 32'd0;
      poll_q <= 24'd0;
    end else begin
      st_q <= st_d;
      dir_q <= dir_d;
      err_q <= err_d;
      done_q <= done_d;
      wblock_q <= wblock_d;
      wa_q <= wa_d;
      wcount_q <= wcount_d;
      idx_q <= idx_d;
      ph_q <= ph_d;
      buf_q <= buf_d;
      poll_q <= poll_d;
      if (cfg_wr && sel == REG_BLOCK) block_q <= s_data_i[25:0];
      if (cfg_wr && sel == REG_MEMADDR) memaddr_q <= {s_data_i[31:2], 2'b00};
      if (cfg_wr && sel == REG_COUNT) count_q <= s_data_i[15:0];
    end
  flash_dma_xfer u_xfer (
    .clk(clk), .rst_n(rst_n), .req_i(req), .we_i(xwe), .addr_i(xaddr), .wdata_i(xwdata),
    .done_o(xdone), .rdata_o(rdata), .m_addr_o(m_addr_o), .m_data_o(m_data_o),
    .m_data_i(m_data_i), .m_rd_o(m_rd_o), .m_we_o(m_we_o), .m_ack_i(m_ack_i)
  );
endmodule

// File: tb/tb_flash_dma.sv
// tb_flash_dma: register-table checks plus randomized DMA jobs against a transaction-level model.
module tb_flash_dma;
  localparam logic [31:0] CTRLA = 32'hFFFF_FE00, BUFA = 32'hFFFF_F000;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] s_addr_i = 4'd0;
  logic [31:0] s_data_i = 32'd0, s_data_o, m_addr_o, m_data_o, m_data_i = 32'd0;
  logic s_we_i = 1'b0, s_ack_o, m_rd_o, m_we_o, m_ack_i = 1'b0, interrupt;
  logic [1:0] m_sel_o;
  always #5 clk = ~clk;
  flash_dma #(.POLL_LIMIT(24'd16)) dut (
    .clk(clk), .rst_n(rst_n), .s_addr_i(s_addr_i), .s_data_i(s_data_i), .s_data_o(s_data_o),
    .s_we_i(s_we_i), .s_ack_o(s_ack_o), .m_addr_o(m_addr_o), .m_data_o(m_data_o),
    .m_data_i(m_data_i), .m_sel_o(m_sel_o), .m_rd_o(m_rd_o), .m_we_o(m_we_o),
    .m_ack_i(m_ack_i), .interrupt(interrupt)
  );
  typedef struct {logic we; logic [31:0] addr; logic [31:0] data;} xact_t;
  typedef struct {logic we; logic [3:0] a; logic [31:0] d; logic [31:0] exp;} vec_t;
  xact_t log_q[$], exp_q[$];
  logic [31:0] mem [logic [31:0]];
  logic [31:0] dbuf [128];
  int dev_polls = 0, dev_p = 1, dly_mode = 0, hold_err = 0, tests = 0, fails = 0;
  bit dev_never = 0;

  function automatic logic [31:0] pat(logic [25:0] b, int i);
    return 32'hA500_0000 + (({6'd0, b} - 32'd5) << 12) + 32'(i);
  endfunction
  function automatic logic [31:0] memrd(logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a ^ 32'h5A5A_C3C3);
  endfunction
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Bus slave: memory, flash buffer window and a flash status register that reports done after dev_p polls.
  task automatic service();
    logic [31:0] off;
    off = m_addr_o - BUFA;
    if (m_we_o) begin
      log_q.push_back('{1'b1, m_addr_o, m_data_o});
      if (m_addr_o == CTRLA) begin
        dev_polls = 0;
        if (m_data_o[30]) for (int i = 0; i < 128; i++) dbuf[i] = pat(m_data_o[25:0], i);
      end else if (m_addr_o >= BUFA && m_addr_o < BUFA + 32'd512) dbuf[off[8:2]] = m_data_o;
      else mem[m_addr_o] = m_data_o;
    end else begin
      log_q.push_back('{1'b0, m_addr_o, 32'd0});
      if (m_addr_o == CTRLA) begin
        dev_polls++;
        m_data_i = (!dev_never && dev_polls >= dev_p) ? 32'h8000_0000 : 32'd0;
      end else if (m_addr_o >= BUFA && m_addr_o < BUFA + 32'd512) m_data_i = dbuf[off[8:2]];
      else m_data_i = memrd(m_addr_o);
    end
  endtask
  initial begin
    int wcnt, cur;
    logic [65:0] held;
    wcnt = 0; cur = 0; held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n || !(m_rd_o || m_we_o)) begin
        m_ack_i = 1'b0;
        wcnt = 0;
      end else begin
        if (wcnt == 0) begin
          held = {m_addr_o, m_data_o, m_rd_o, m_we_o};
          cur = dly_mode < 0 ? int'($urandom_range(0, 3)) : dly_mode;
        end else if ({m_addr_o, m_data_o, m_rd_o, m_we_o} !== held) hold_err++;
        if (m_rd_o && m_we_o) hold_err++;
        if (wcnt == cur) begin
          m_ack_i = 1'b1;
          wcnt = 0;
          service();
        end else begin
          m_ack_i = 1'b0;
          wcnt++;
        end
      end
    end
  end

  // Expected bus transaction list for a whole job, derived from the job-level description.
  task automatic build_exp(bit dir, logic [25:0] blk, logic [31:0] ma, int cnt, int p, bit never);
    logic [25:0] b;
    logic [31:0] wa;
    exp_q.delete();
    for (int k = 0; k < cnt; k++) begin
      b = blk + 26'(k);
      wa = (ma & ~32'd3) + 32'(512 * k);
      if (dir) for (int i = 0; i < 128; i++) begin
        exp_q.push_back('{1'b0, wa + 32'(4 * i), 32'd0});
        exp_q.push_back('{1'b1, BUFA + 32'(4 * i), memrd(wa + 32'(4 * i))});
      end
      exp_q.push_back('{1'b1, CTRLA, (dir ? 32'h2000_0000 : 32'h4000_0000) | {6'd0, b}});
      for (int j = 0; j < (never ? 16 : p); j++) exp_q.push_back('{1'b0, CTRLA, 32'd0});
      exp_q.push_back('{1'b1, CTRLA, 32'd0});
      if (never) break;
      if (!dir) for (int i = 0; i < 128; i++) begin
        exp_q.push_back('{1'b0, BUFA + 32'(4 * i), 32'd0});
        exp_q.push_back('{1'b1, wa + 32'(4 * i), pat(b, i)});
      end
    end
  endtask
  task automatic cmp_log(string name);
    int bad;
    bad = -1;
    check({name, " xact count"}, 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      if (bad < 0 && (log_q[i].we !== exp_q[i].we || log_q[i].addr !== exp_q[i].addr ||
                      log_q[i].data !== exp_q[i].data)) bad = i;
    tests++;
    if (bad >= 0) begin
      fails++;
      $display("FAIL %s xact %0d: got we=%0b a=%h d=%h required we=%0b a=%h d=%h", name, bad,
               log_q[bad].we, log_q[bad].addr, log_q[bad].data,
               exp_q[bad].we, exp_q[bad].addr, exp_q[bad].data);
    end
  endtask
  task automatic cfg_wr(logic [3:0] a, logic [31:0] d);
    @(negedge clk);
    s_addr_i = a; s_data_i = d; s_we_i = 1'b1;
    @(posedge clk);
    #1 s_we_i = 1'b0;
  endtask
  task automatic cfg_rd(logic [3:0] a, output logic [31:0] d);
    s_addr_i = a;
    #1 d = s_data_o;
  endtask
  task automatic prog(bit dir, logic [25:0] blk, logic [31:0] ma, int cnt);
    cfg_wr(4'h4, {6'd0, blk});
    cfg_wr(4'h8, ma);
    cfg_wr(4'hC, 32'(cnt));
    cfg_wr(4'h0, {30'd0, dir, 1'b1});
  endtask
  task automatic wait_done(string name);
    for (int c = 0; c < 20000 && !interrupt; c++) begin
      @(posedge clk);
      #1;
    end
    check({name, " interrupt"}, 32'(interrupt), 32'd1);
  endtask
  task automatic run_job(string name, bit dir, logic [25:0] blk, logic [31:0] ma, int cnt,
                         int p, bit never, int dly);
    logic [31:0] r;
    dev_p = p; dev_never = never; dly_mode = dly; hold_err = 0; dev_polls = 0;
    log_q.delete();
    build_exp(dir, blk, ma, cnt, p, never);
    prog(dir, blk, ma, cnt);
    wait_done(name);
    cmp_log(name);
    cfg_rd(4'h0, r);
    check({name, " ctrl"}, r, {1'b1, 1'b0, never, 27'd0, dir, 1'b0});
    cfg_rd(4'h4, r);
    check({name, " block"}, r, {6'd0, blk});
    cfg_rd(4'h8, r);
    check({name, " memaddr"}, r, ma & ~32'd3);
    cfg_rd(4'hC, r);
    check({name, " count"}, r, 32'(cnt));
    check({name, " hold"}, 32'(hold_err), 32'd0);
    cfg_wr(4'h0, 32'h8000_0000);
    check({name, " irq clear"}, 32'(interrupt), 32'd0);
  endtask

  initial begin
    vec_t tbl[9];
    logic [31:0] r;
    int n, m, found;
    tbl[0] = '{1'b1, 4'h4, 32'hFFFF_FFFF, 32'h03FF_FFFF};
    tbl[1] = '{1'b1, 4'h8, 32'h1234_5677, 32'h1234_5674};
    tbl[2] = '{1'b1, 4'hC, 32'hABCD_0003, 32'h0000_0003};
    tbl[3] = '{1'b1, 4'h0, 32'h0000_0002, 32'h0000_0002};
    tbl[4] = '{1'b0, 4'h5, 32'h0, 32'h03FF_FFFF};
    tbl[5] = '{1'b1, 4'hC, 32'h0, 32'h0};
    tbl[6] = '{1'b1, 4'h0, 32'h0000_0001, 32'h8000_0000};
    tbl[7] = '{1'b1, 4'h0, 32'h8000_0000, 32'h0};
    tbl[8] = '{1'b0, 4'hB, 32'h0, 32'h1234_5674};
    repeat (2) @(posedge clk);
    #1;
    check("rst m_rd", 32'(m_rd_o), 0);
    check("rst m_we", 32'(m_we_o), 0);
    check("rst m_addr", m_addr_o, 0);
    check("rst m_data", m_data_o, 0);
    check("rst irq", 32'(interrupt), 0);
    check("rst ack/sel", {30'd0, s_ack_o, m_sel_o[1]}, 32'd3);
    for (int i = 0; i < 4; i++) begin
      cfg_rd(4'(4 * i), r);
      check("rst reg", r, 0);
    end
    @(negedge clk) rst_n = 1'b1;
    foreach (tbl[i]) begin
      if (tbl[i].we) cfg_wr(tbl[i].a, tbl[i].d);
      cfg_rd(tbl[i].a, r);
      check($sformatf("reg row %0d", i), r, tbl[i].exp);
      if (tbl[i].a[3:2] == 2'd0) check($sformatf("reg row %0d irq", i), 32'(interrupt), 32'(tbl[i].exp[31]));
    end
    run_job("t1 read", 0, 26'd5, 32'h0000_1000, 1, 3, 0, 0);
    n = 0;
    for (int i = 0; i < 128; i++)
      if (!mem.exists(32'h1000 + 32'(4 * i)) || mem[32'h1000 + 32'(4 * i)] !== 32'hA500_0000 + 32'(i)) n++;
    check("t1 mem words wrong", 32'(n), 0);
    run_job("t2 write wrap", 1, 26'h3FF_FFFF, 32'h0002_0000, 2, 2, 0, 0);
    n = 0; m = 0;
    foreach (log_q[i]) begin
      if (log_q[i].we && log_q[i].addr == CTRLA && log_q[i].data == 32'h2000_0000) n++;
      if (log_q[i].we && log_q[i].addr >= BUFA && log_q[i].addr < BUFA + 32'd512) m++;
    end
    check("t2 kick block0", 32'(n), 1);
    check("t2 buf writes", 32'(m), 256);
    run_job("t3 timeout", 0, 26'd11, 32'h0000_3000, 1, 1, 1, 0);
    n = 0; m = 0;
    foreach (log_q[i]) begin
      if (!log_q[i].we && log_q[i].addr == CTRLA) n++;
      if (log_q[i].addr >= BUFA && log_q[i].addr < BUFA + 32'd512) m++;
    end
    check("t3 polls", 32'(n), 16);
    check("t3 drain", 32'(m), 0);
    run_job("t4 slow ack", 0, 26'd20, 32'h0000_5000, 1, 2, 0, 3);
    dev_p = 2; dev_never = 0; dly_mode = 0; dev_polls = 0;
    prog(0, 26'd9, 32'h0000_4000, 1);
    found = 0;
    for (int c = 0; c < 5000 && found == 0; c++) begin
      @(posedge clk);
      #1;
      if (m_rd_o && m_addr_o == BUFA + 32'd160) found = 1;
    end
    check("t5 reached word 40", 32'(found), 1);
    rst_n = 1'b0;
    #1;
    check("t5 async rd", 32'(m_rd_o), 0);
    check("t5 async we", 32'(m_we_o), 0);
    cfg_rd(4'h0, r);
    check("t5 ctrl", r, 0);
    dev_polls = 0;
    @(negedge clk) rst_n = 1'b1;
    run_job("t5 after reset", 0, 26'd9, 32'h0000_4000, 1, 2, 0, 0);
    dev_p = 4; dev_never = 0; dly_mode = 0; hold_err = 0; dev_polls = 0;
    log_q.delete();
    build_exp(0, 26'd7, 32'h0000_8000, 1, 4, 0);
    prog(0, 26'd7, 32'h0000_8000, 1);
    cfg_rd(4'h0, r);
    check("t6 busy", r & 32'h4000_0000, 32'h4000_0000);
    cfg_wr(4'h0, 32'h0000_0003);
    cfg_wr(4'h4, 32'h0000_0123);
    wait_done("t6 busy job");
    cmp_log("t6 busy job");
    cfg_rd(4'h4, r);
    check("t6 block kept", r, 32'd7);
    cfg_rd(4'h0, r);
    check("t6 ctrl", r, 32'h8000_0000);
    cfg_wr(4'h0, 32'h8000_0000);
    for (int k = 0; k < 4; k++) begin
      bit d;
      logic [25:0] b;
      d = 1'($urandom_range(0, 1));
      b = k == 0 ? 26'h3FF_FFFF : 26'($urandom);
      run_job($sformatf("rand%0d", k), d, b, $urandom & 32'h0FFF_FFFF,
              int'($urandom_range(1, 2)), int'($urandom_range(1, 8)), 0, -1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
